divider_taint_track_bitwise: RTL and testbench

Constant-time sequential restoring divider with bitwise taint tracking; the inverse-arithmetic counterpart to the team's taint-tracked shift-add multiplier. It takes a WIDTH-bit dividend and divisor plus per-bit taint vectors and runs exactly WIDTH iterations regardless of data values. It returns quotient and remainder with conservatively propagated taint. It sits beside the multiplier in the information-flow test harness.

---
 rtl/divider_taint_track_bitwise_pkg.sv | 41 ++++
 rtl/divider_control_taint_track_bitwise.sv | 80 ++++++++
 rtl/divider_taint_track_bitwise.sv | 135 +++++++++++++
 tb/tb_divider_taint_track_bitwise.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_taint_track_bitwise_pkg.sv
// Shared types and helpers for the taint-tracked restoring divider.
// Taint logic in the top and control blocks is built only under DIVIDER_TAINT_TRACK_EN.
package divider_taint_track_bitwise_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Taint helpers work on a fixed wide vector; callers zero-extend and slice back.
  // WIDTH must therefore stay below MAX_WIDTH.
  localparam int MAX_WIDTH = 2048;
  typedef logic [MAX_WIDTH:0] wide_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Carry-chain taint: bit i is tainted if any operand bit at or below i is.
  function automatic wide_t prefix_or2(input wide_t a, input wide_t b);
    wide_t r;
    logic  acc;
    acc = 1'b0;
    r   = '0;
    for (int i = 0; i <= MAX_WIDTH; i++) begin
      acc  = acc | a[i] | b[i];
      r[i] = acc;
    end
    return r;
  endfunction

  // Taint of a 2:1 mux: a tainted select taints every result bit.
  function automatic wide_t tmux_t(input logic sel, input logic sel_t,
                                   input wide_t a_t, input wide_t b_t);
    if (sel_t) return '1;
    return sel ? a_t : b_t;
  endfunction

endpackage

// File: rtl/divider_control_taint_track_bitwise.sv
// FSM, iteration counter and control taint for the restoring divider.
// ctrl_t exists only under DIVIDER_TAINT_TRACK_EN; otherwise all control taints are 0.
module divider_control_taint_track_bitwise
  import divider_taint_track_bitwise_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   start_t,
  output logic   load_en,
  output logic   load_en_t,
  output logic   shift_en,
  output logic   shift_en_t,
  output logic   done,
  output logic   done_t,
  output state_e state_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ctrl_t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DIVIDER_TAINT_TRACK_EN
  logic ctrl_t_q;

  // Captured on the same edge that accepts start, so it already covers LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_t_q <= 1'b0;
    else if (state_q == ST_IDLE && start) ctrl_t_q <= start_t;
  end

  assign ctrl_t = ctrl_t_q;
`else
  logic unused_start_t;
  assign unused_start_t = start_t;
  assign ctrl_t = 1'b0;
`endif

  assign load_en    = (state_q == ST_LOAD);
  assign shift_en   = (state_q == ST_RUN);
  assign load_en_t  = ctrl_t;
  assign shift_en_t = ctrl_t;
  assign done       = (state_q == ST_DONE);
  assign done_t     = done & ctrl_t;
  assign state_o    = state_q;

endmodule

// File: rtl/divider_taint_track_bitwise.sv
// Constant-time restoring divider with per-bit taint on quotient and remainder.
// Taint datapath present only when DIVIDER_TAINT_TRACK_EN is defined.
module divider_taint_track_bitwise
  import divider_taint_track_bitwise_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             done,
  output logic             done_t,
  output logic [1:0]       dbg_state
);

  logic   load_en, load_en_t, shift_en, shift_en_t;
  state_e state;

  divider_control_taint_track_bitwise #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_t    (start_t),
    .load_en    (load_en),
    .load_en_t  (load_en_t),
    .shift_en   (shift_en),
    .shift_en_t (shift_en_t),
    .done       (done),
    .done_t     (done_t),
    .state_o    (state)
  );

  assign dbg_state = state;

  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic [WIDTH:0]   r_q, r_d, r_sh, trial;
  logic             qb;

  always_comb begin
    r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial = r_sh - {1'b0, d_q};
    qb    = ~trial[WIDTH];
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    if (load_en) begin
      q_d = dividend;
      r_d = '0;
      d_d = divisor;
    end else if (shift_en) begin
      // Both paths are always evaluated; qb only selects.
      r_d = qb ? trial : r_sh;
      q_d = {q_q[WIDTH-2:0], qb};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
    end
  end

  // R never exceeds the divisor after an iteration, so its MSB is not observable.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  assign quotient  = q_q;
  assign remainder = r_q[WIDTH-1:0];

`ifdef DIVIDER_TAINT_TRACK_EN
  logic [WIDTH-1:0] q_t_q, q_t_d, d_t_q, d_t_d;
  logic [WIDTH:0]   r_t_q, r_t_d, r_sh_t, diff_t;
  logic             qb_t;
  wide_t            diff_w, rmux_w;

  always_comb begin
    r_sh_t = {r_t_q[WIDTH-1:0], q_t_q[WIDTH-1]};
    qb_t   = (|r_sh_t) | (|d_t_q);
    diff_w = prefix_or2(wide_t'(r_sh_t), wide_t'({1'b0, d_t_q}));
    diff_t = diff_w[WIDTH:0];
    rmux_w = tmux_t(qb, qb_t, wide_t'(diff_t), wide_t'(r_sh_t));
    q_t_d  = q_t_q;
    r_t_d  = r_t_q;
    d_t_d  = d_t_q;
    if (load_en) begin
      q_t_d = load_en_t ? '1 : dividend_t;
      r_t_d = load_en_t ? '1 : '0;
      d_t_d = divisor_t;
    end else if (shift_en) begin
      q_t_d = shift_en_t ? '1 : {q_t_q[WIDTH-2:0], qb_t};
      r_t_d = shift_en_t ? '1 : rmux_w[WIDTH:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_t_q <= '0;
      r_t_q <= '0;
      d_t_q <= '0;
    end else begin
      q_t_q <= q_t_d;
      r_t_q <= r_t_d;
      d_t_q <= d_t_d;
    end
  end

  logic unused_r_t_msb;
  assign unused_r_t_msb = r_t_q[WIDTH];

  assign quotient_t  = q_t_q;
  assign remainder_t = r_t_q[WIDTH-1:0];
`else
  logic unused_taint;
  assign unused_taint = ^{dividend_t, divisor_t, load_en_t, shift_en_t};

  assign quotient_t  = '0;
  assign remainder_t = '0;
`endif

endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
// Self-checking bench for divider_taint_track_bitwise at WIDTH=8.
// Taint expectations follow DIVIDER_TAINT_TRACK_EN as seen by this file.
module tb_divider_taint_track_bitwise;
  import divider_taint_track_bitwise_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start_t;
  logic [W-1:0] dividend, dividend_t, divisor, divisor_t;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
  logic         done, done_t;
  logic [1:0]   dbg_state;

  divider_taint_track_bitwise #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_t     (start_t),
    .dividend    (dividend),
    .dividend_t  (dividend_t),
    .divisor     (divisor),
    .divisor_t   (divisor_t),
    .quotient    (quotient),
    .quotient_t  (quotient_t),
    .remainder   (remainder),
    .remainder_t (remainder_t),
    .done        (done),
    .done_t      (done_t),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] a, b, a_t, b_t;
    logic         s_t;
    logic [W-1:0] q, r, q_t, r_t;
    logic         d_t;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] q, r, q_t, r_t;
    logic         d_t;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [W-1:0] tx(input logic [W-1:0] v);
`ifdef DIVIDER_TAINT_TRACK_EN
    return v;
`else
    return (v & '0);
`endif
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, b, a_t, b_t, input logic s_t,
                              input logic [W-1:0] q, r, q_t, r_t, input logic d_t);
    vec_t v;
    v.a = a; v.b = b; v.a_t = a_t; v.b_t = b_t; v.s_t = s_t;
    v.q = q; v.r = r; v.q_t = tx(q_t); v.r_t = tx(r_t); v.d_t = tx({7'd0, d_t}) != 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.q = v.q; e.r = v.r; e.q_t = v.q_t; e.r_t = v.r_t; e.d_t = v.d_t;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({name, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, " quotient"},    quotient,    e.q);
      check({name, " remainder"},   remainder,   e.r);
      check({name, " quotient_t"},  quotient_t,  e.q_t);
      check({name, " remainder_t"}, remainder_t, e.r_t);
      check({name, " done_t"},      done_t,      e.d_t);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_start(input vec_t v);
    @(negedge clk);
    dividend = v.a; divisor = v.b; dividend_t = v.a_t; divisor_t = v.b_t;
    start = 1'b1; start_t = v.s_t;
    push_exp(v);
    @(negedge clk);
    start = 1'b0; start_t = 1'b0;
  endtask

  // Called at the negedge right after the edge that sampled start.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    drive_start(v);
    wait_done(cyc);
    // done is high in the cycle after edge W+1; that cycle closes at edge W+2.
    check({name, " latency"}, cyc + 1, W + 2);
    pop_check(name);
    @(negedge clk);
    check({name, " done pulse"}, done, 1'b0);
  endtask

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, first, second, ndone;
    vec_t v;

    tbl[0]  = mk(8'd100, 8'd7,   8'h00, 8'h00, 1'b0, 8'd14,  8'd2,   8'h00, 8'h00, 1'b0);
    tbl[1]  = mk(8'd200, 8'd0,   8'h00, 8'h00, 1'b0, 8'd255, 8'd200, 8'h00, 8'h00, 1'b0);
    tbl[2]  = mk(8'd100, 8'd7,   8'h01, 8'h00, 1'b0, 8'd14,  8'd2,   8'h01, 8'hFF, 1'b0);
    tbl[3]  = mk(8'd100, 8'd7,   8'h00, 8'h00, 1'b1, 8'd14,  8'd2,   8'hFF, 8'hFF, 1'b1);
    tbl[4]  = mk(8'd100, 8'd7,   8'h00, 8'h01, 1'b0, 8'd14,  8'd2,   8'hFF, 8'hFF, 1'b0);
    tbl[5]  = mk(8'd255, 8'd255, 8'h00, 8'h00, 1'b0, 8'd1,   8'd0,   8'h00, 8'h00, 1'b0);
    tbl[6]  = mk(8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 8'd0,   8'd0,   8'h00, 8'h00, 1'b0);
    tbl[7]  = mk(8'd255, 8'd1,   8'h00, 8'h00, 1'b0, 8'd255, 8'd0,   8'h00, 8'h00, 1'b0);
    tbl[8]  = mk(8'd5,   8'd200, 8'h00, 8'h00, 1'b0, 8'd0,   8'd5,   8'h00, 8'h00, 1'b0);
    tbl[9]  = mk(8'd100, 8'd7,   8'h80, 8'h00, 1'b0, 8'd14,  8'd2,   8'hFF, 8'hFF, 1'b0);
    tbl[10] = mk(8'd0,   8'd0,   8'h00, 8'h00, 1'b0, 8'd255, 8'd0,   8'h00, 8'h00, 1'b0);

    // Reset state
    rst = 1'b0; start = 1'b0; start_t = 1'b0;
    dividend = '0; divisor = '0; dividend_t = '1; divisor_t = '1;
    #12;
    check("reset quotient",    quotient,    8'd0);
    check("reset remainder",   remainder,   8'd0);
    check("reset quotient_t",  quotient_t,  8'd0);
    check("reset remainder_t", remainder_t, 8'd0);
    check("reset done",        done,        1'b0);
    check("reset done_t",      done_t,      1'b0);
    check("reset state",       dbg_state,   ST_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Random operands, untainted, with an arithmetic reference
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (i == 0) b = '0;
      v = mk(a, b, 8'h00, 8'h00, 1'b0, (b == 0) ? 8'hFF : a / b, (b == 0) ? a : a % b,
             8'h00, 8'h00, 1'b0);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // start held high: back-to-back operations
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; dividend_t = '0; divisor_t = '0;
    start = 1'b1; start_t = 1'b0;
    push_exp(tbl[0]); push_exp(tbl[0]);
    cyc = 0; first = -1; second = -1;
    while (second < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = cyc;
          pop_check("b2b first");
        end else begin
          second = cyc;
          start = 1'b0;
          pop_check("b2b second");
        end
      end
    end
    check("b2b first latency", first, W + 2);
    check("b2b period", second - first, W + 3);
    @(negedge clk);

    // start pulses during RUN and DONE are ignored
    drive_start(tbl[0]);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ignore latency", cyc + 6, W + 2);
    pop_check("ignore");
    ndone = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("ignore done count", ndone, 1);
    check("ignore state", dbg_state, ST_IDLE);

    // Reset after four iterations aborts the operation
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; dividend_t = 8'h01; divisor_t = '0;
    start = 1'b1; start_t = 1'b1;
    @(negedge clk);
    start = 1'b0; start_t = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-abort state", dbg_state, ST_RUN);
    rst = 1'b0;
    #1;
    check("abort state",       dbg_state,   ST_IDLE);
    check("abort quotient",    quotient,    8'd0);
    check("abort remainder",   remainder,   8'd0);
    check("abort quotient_t",  quotient_t,  8'd0);
    check("abort remainder_t", remainder_t, 8'd0);
    check("abort done",        done,        1'b0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort no done", ndone, 0);

    // Divider still works after the abort
    run_vec(tbl[2], "post-abort");

    check("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
